// File: rtl/adventure_grid_nav.sv
// Grid-of-rooms navigator: edge-detected N/E/S/W presses move the player
// across a COLS x ROWS map defined by open-door bitmasks, with one locked
// room, a saturating move counter and a sticky win flag.
module adventure_grid_nav #(
  parameter int                   COLS       = 4,
  parameter int                   ROWS       = 4,
  parameter int                   RW         = $clog2(COLS*ROWS),
  parameter int                   START_ROOM = 0,
  parameter int                   LOCK_ROOM  = 15,
  parameter int                   GOAL_ROOM  = 15,
  parameter logic [COLS*ROWS-1:0] OPEN_E     = '1,
  parameter logic [COLS*ROWS-1:0] OPEN_S     = '1
) (
  input  logic          CLK,
  input  logic          Reset,
  input  logic          N,
  input  logic          E,
  input  logic          S,
  input  logic          W,
  input  logic          sword,
  output logic [RW-1:0] rooms,
  output logic [3:0]    pos_x,
  output logic [3:0]    pos_y,
  output logic          moved,
  output logic          blocked,
  output logic [7:0]    moves,
  output logic          won
);

  localparam logic [3:0] START_X = 4'(START_ROOM % COLS);
  localparam logic [3:0] START_Y = 4'(START_ROOM / COLS);

  logic [3:0]  btn;
  logic [3:0]  prev;
  logic [3:0]  rise;
  logic        press;
  logic        legal;
  int unsigned cx;
  int unsigned cy;
  int unsigned cur;
  int unsigned tx;
  int unsigned ty;
  int unsigned tidx;

  assign btn  = {N, E, S, W};
  assign rise = btn & ~prev;

  // Pick the highest-priority rising edge (N > E > S > W) and judge the move.
  always_comb begin
    cx    = 32'(pos_x);
    cy    = 32'(pos_y);
    cur   = cy * COLS + cx;
    tx    = cx;
    ty    = cy;
    press = 1'b0;
    legal = 1'b0;
    if (!won && rise != '0) begin
      press = 1'b1;
      if (rise[3]) begin
        if (cy > 0 && OPEN_S[RW'(cur - COLS)]) begin
          legal = 1'b1;
          ty    = cy - 1;
        end
      end else if (rise[2]) begin
        if (cx < COLS - 1 && OPEN_E[RW'(cur)]) begin
          legal = 1'b1;
          tx    = cx + 1;
        end
      end else if (rise[1]) begin
        if (cy < ROWS - 1 && OPEN_S[RW'(cur)]) begin
          legal = 1'b1;
          ty    = cy + 1;
        end
      end else begin
        if (cx > 0 && OPEN_E[RW'(cur - 1)]) begin
          legal = 1'b1;
          tx    = cx - 1;
        end
      end
    end
    tidx = ty * COLS + tx;
    if (legal && tidx == LOCK_ROOM && !sword) begin
      legal = 1'b0;
    end
  end

  // Registered position, status pulses, counter and win latch.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      prev    <= '1;
      rooms   <= RW'(START_ROOM);
      pos_x   <= START_X;
      pos_y   <= START_Y;
      moved   <= 1'b0;
      blocked <= 1'b0;
      moves   <= '0;
      won     <= 1'b0;
    end else begin
      prev    <= btn;
      moved   <= press && legal;
      blocked <= press && !legal;
      if (press && legal) begin
        rooms <= RW'(tidx);
        pos_x <= 4'(tx);
        pos_y <= 4'(ty);
        if (moves != '1) begin
          moves <= moves + 8'd1;
        end
        if (tidx == GOAL_ROOM) begin
          won <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_adventure_grid_nav.sv
// Bench for adventure_grid_nav: a default-map instance and a walled-map
// instance share stimulus; both are compared every cycle to a grid model.
module tb_adventure_grid_nav;

  localparam int COLS = 4;
  localparam int ROWS = 4;

  logic       CLK;
  logic       Reset;
  logic       N, E, S, W, sword;
  logic [3:0] rooms_a, pos_x_a, pos_y_a, rooms_b, pos_x_b, pos_y_b;
  logic       moved_a, blocked_a, won_a, moved_b, blocked_b, won_b;
  logic [7:0] moves_a, moves_b;

  int tests;
  int fails;

  adventure_grid_nav dut_a (
    .CLK(CLK), .Reset(Reset), .N(N), .E(E), .S(S), .W(W), .sword(sword),
    .rooms(rooms_a), .pos_x(pos_x_a), .pos_y(pos_y_a), .moved(moved_a),
    .blocked(blocked_a), .moves(moves_a), .won(won_a)
  );

  adventure_grid_nav #(
    .LOCK_ROOM(10),
    .GOAL_ROOM(12),
    .OPEN_E(16'h5B7E),
    .OPEN_S(16'hF7DF)
  ) dut_b (
    .CLK(CLK), .Reset(Reset), .N(N), .E(E), .S(S), .W(W), .sword(sword),
    .rooms(rooms_b), .pos_x(pos_x_b), .pos_y(pos_y_b), .moved(moved_b),
    .blocked(blocked_b), .moves(moves_b), .won(won_b)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model: player coordinates on the grid, doors looked up by the
  // pair of rooms they separate.
  logic [15:0] oe [2];
  logic [15:0] os [2];
  int          lock_room [2];
  int          goal_room [2];
  int          mx [2];
  int          my [2];
  int          mmoves [2];
  bit          mwon [2];
  bit [3:0]    mprev [2];
  bit          mmoved [2];
  bit          mblocked [2];

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      mx[d] = 0; my[d] = 0; mmoves[d] = 0; mwon[d] = 0;
      mprev[d] = 4'b1111; mmoved[d] = 0; mblocked[d] = 0;
    end
  endtask

  task automatic model_step(input int d, input bit [3:0] b, input bit sw);
    bit [3:0] r;
    int dx, dy, nx, ny;
    bit ok;
    r = b & ~mprev[d];
    mmoved[d] = 0;
    mblocked[d] = 0;
    dx = 0; dy = 0;
    if (r != 0 && !mwon[d]) begin
      if (r[3]) dy = -1;
      else if (r[2]) dx = 1;
      else if (r[1]) dy = 1;
      else dx = -1;
      nx = mx[d] + dx;
      ny = my[d] + dy;
      ok = (nx >= 0 && nx < COLS && ny >= 0 && ny < ROWS);
      if (ok) begin
        if (dx != 0) ok = oe[d][my[d] * COLS + ((nx < mx[d]) ? nx : mx[d])];
        else         ok = os[d][((ny < my[d]) ? ny : my[d]) * COLS + mx[d]];
      end
      if (ok && ny * COLS + nx == lock_room[d] && !sw) ok = 0;
      if (ok) begin
        mx[d] = nx; my[d] = ny;
        if (mmoves[d] < 255) mmoves[d]++;
        if (ny * COLS + nx == goal_room[d]) mwon[d] = 1;
        mmoved[d] = 1;
      end else begin
        mblocked[d] = 1;
      end
    end
    mprev[d] = b;
  endtask

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_dut(input int d, input logic [3:0] r, input logic [3:0] px,
                           input logic [3:0] py, input logic mv, input logic bl,
                           input logic [7:0] mvs, input logic wn);
    string p;
    p = (d == 0) ? "a" : "b";
    check({p, ".rooms"}, int'(r), my[d] * COLS + mx[d]);
    check({p, ".pos_x"}, int'(px), mx[d]);
    check({p, ".pos_y"}, int'(py), my[d]);
    check({p, ".moved"}, int'(mv), int'(mmoved[d]));
    check({p, ".blocked"}, int'(bl), int'(mblocked[d]));
    check({p, ".moves"}, int'(mvs), mmoves[d]);
    check({p, ".won"}, int'(wn), int'(mwon[d]));
  endtask

  task automatic check_all();
    check_dut(0, rooms_a, pos_x_a, pos_y_a, moved_a, blocked_a, moves_a, won_a);
    check_dut(1, rooms_b, pos_x_b, pos_y_b, moved_b, blocked_b, moves_b, won_b);
  endtask

  task automatic step(input bit [3:0] b, input bit sw);
    {N, E, S, W} = b;
    sword = sw;
    @(posedge CLK);
    model_step(0, b, sw);
    model_step(1, b, sw);
    #1;
    check_all();
  endtask

  // Asynchronous reset asserted between clock edges, whatever buttons are held.
  task automatic do_reset();
    #2;
    Reset = 1'b1;
    model_reset();
    #1;
    check_all();
    @(posedge CLK);
    #3;
    Reset = 1'b0;
  endtask

  typedef struct {
    bit [3:0] b;
    bit       sw;
    int       rooms;
    bit       moved;
    bit       blocked;
    int       moves;
    bit       won;
  } vec_t;

  vec_t tbl[$];

  initial begin
    bit [3:0] rb;
    tests = 0;
    fails = 0;
    oe[0] = 16'hFFFF; os[0] = 16'hFFFF; lock_room[0] = 15; goal_room[0] = 15;
    oe[1] = 16'h5B7E; os[1] = 16'hF7DF; lock_room[1] = 10; goal_room[1] = 12;
    {N, E, S, W} = 4'b0000;
    sword = 1'b0;
    Reset = 1'b1;
    model_reset();
    #1;

    // Directed walk on the default map: edges, hold, lock, goal, frozen after win.
    tbl.push_back('{4'b0000, 0,  0, 0, 0, 0, 0});
    tbl.push_back('{4'b1000, 0,  0, 0, 1, 0, 0});
    tbl.push_back('{4'b0000, 0,  0, 0, 0, 0, 0});
    tbl.push_back('{4'b0001, 0,  0, 0, 1, 0, 0});
    tbl.push_back('{4'b0000, 0,  0, 0, 0, 0, 0});
    tbl.push_back('{4'b0100, 0,  1, 1, 0, 1, 0});
    tbl.push_back('{4'b0100, 0,  1, 0, 0, 1, 0});
    tbl.push_back('{4'b0000, 0,  1, 0, 0, 1, 0});
    tbl.push_back('{4'b0100, 0,  2, 1, 0, 2, 0});
    tbl.push_back('{4'b0000, 0,  2, 0, 0, 2, 0});
    tbl.push_back('{4'b0010, 0,  6, 1, 0, 3, 0});
    tbl.push_back('{4'b0000, 0,  6, 0, 0, 3, 0});
    tbl.push_back('{4'b0010, 0, 10, 1, 0, 4, 0});
    tbl.push_back('{4'b0000, 0, 10, 0, 0, 4, 0});
    tbl.push_back('{4'b0010, 0, 14, 1, 0, 5, 0});
    tbl.push_back('{4'b0000, 0, 14, 0, 0, 5, 0});
    tbl.push_back('{4'b0100, 0, 14, 0, 1, 5, 0});
    tbl.push_back('{4'b0000, 0, 14, 0, 0, 5, 0});
    tbl.push_back('{4'b0001, 0, 13, 1, 0, 6, 0});
    tbl.push_back('{4'b0000, 0, 13, 0, 0, 6, 0});
    tbl.push_back('{4'b0100, 0, 14, 1, 0, 7, 0});
    tbl.push_back('{4'b0000, 0, 14, 0, 0, 7, 0});
    tbl.push_back('{4'b0100, 1, 15, 1, 0, 8, 1});
    tbl.push_back('{4'b0000, 1, 15, 0, 0, 8, 1});
    tbl.push_back('{4'b0001, 1, 15, 0, 0, 8, 1});
    tbl.push_back('{4'b0000, 1, 15, 0, 0, 8, 1});
    tbl.push_back('{4'b1000, 1, 15, 0, 0, 8, 1});

    check("rst.rooms_a", int'(rooms_a), 0);
    check("rst.moves_a", int'(moves_a), 0);
    @(posedge CLK);
    #3;
    Reset = 1'b0;
    foreach (tbl[i]) begin
      step(tbl[i].b, tbl[i].sw);
      check($sformatf("tbl%0d.rooms", i), int'(rooms_a), tbl[i].rooms);
      check($sformatf("tbl%0d.moved", i), int'(moved_a), int'(tbl[i].moved));
      check($sformatf("tbl%0d.blocked", i), int'(blocked_a), int'(tbl[i].blocked));
      check($sformatf("tbl%0d.moves", i), int'(moves_a), tbl[i].moves);
      check($sformatf("tbl%0d.won", i), int'(won_a), int'(tbl[i].won));
    end

    // Reset mid-cycle with E held, then E must be released before it counts.
    step(4'b0100, 0);
    do_reset();
    check("midrst.rooms", int'(rooms_a), 0);
    check("midrst.moves", int'(moves_a), 0);
    check("midrst.won", int'(won_a), 0);
    step(4'b0100, 0);
    check("held.rooms", int'(rooms_a), 0);
    check("held.moved", int'(moved_a), 0);
    step(4'b0000, 0);
    step(4'b0100, 0);
    check("e.rooms", int'(rooms_a), 1);
    check("e.moved", int'(moved_a), 1);
    check("e.moves", int'(moves_a), 1);
    check("wall.blocked_b", int'(blocked_b), 1);
    check("wall.rooms_b", int'(rooms_b), 0);
    step(4'b0100, 0);
    check("e.moved_once", int'(moved_a), 0);
    step(4'b0000, 0);
    step(4'b0010, 0);
    check("s.rooms_b", int'(rooms_b), 4);
    step(4'b0000, 0);
    step(4'b0100, 0);
    check("se.rooms_b", int'(rooms_b), 5);
    check("se.rooms_a", int'(rooms_a), 6);

    // Simultaneous N and E at room 4: N wins, E is dropped.
    do_reset();
    step(4'b0000, 0);
    step(4'b0010, 0);
    step(4'b0000, 0);
    step(4'b1100, 0);
    check("ne.rooms", int'(rooms_a), 0);
    check("ne.moves", int'(moves_a), 2);
    step(4'b0100, 0);
    check("ne.no_late_e", int'(rooms_a), 0);
    check("ne.no_moved", int'(moved_a), 0);
    check("ne.no_blocked", int'(blocked_a), 0);

    // 260 alternating moves: counter saturates.
    do_reset();
    step(4'b0000, 0);
    for (int i = 0; i < 130; i++) begin
      step(4'b0100, 0);
      step(4'b0000, 0);
      step(4'b0001, 0);
      step(4'b0000, 0);
    end
    check("sat.moves", int'(moves_a), 255);
    check("sat.rooms", int'(rooms_a), 0);

    // Random presses, sword toggling and occasional async resets.
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 199) == 0 ||
          (mwon[0] && mwon[1] && $urandom_range(0, 19) == 0)) begin
        do_reset();
      end else begin
        for (int k = 0; k < 4; k++) rb[k] = ($urandom_range(0, 2) == 0);
        step(rb, 1'($urandom_range(0, 1)));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
